// File: rtl/mux_bus_arbiter_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// Holds the FSM encoding and the requester count used by every block.
package mux_bus_arbiter_pkg;

    localparam int NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAX_BURST  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/Mux4x16.sv
// 4:1 bus multiplexer used as the arbiter datapath.
// Purely combinational; the select comes from the arbiter's owner register.
module Mux4x16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in0;
        case (sel)
            2'd1:    out = in1;
            2'd2:    out = in2;
            2'd3:    out = in3;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin winner finder for four requesters.
// Scans req starting at ptr and wrapping; the first set bit wins.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] idx;

    // Walk from farthest to nearest so the nearest hit overwrites last.
    always_comb begin
        winner = 2'd0;
        any    = 1'b0;
        idx    = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            idx = ptr + 2'(j);
            if (req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter owning the select of a shared 4:1 bus.
// Grants one requester for a bounded burst, then rotates with no bubble.
module mux_bus_arbiter
    import mux_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEL_WIDTH  = 2,
    parameter int MAX_BURST  = DEF_MAX_BURST,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic [DATA_WIDTH-1:0] in3,
    output logic [NUM_REQ-1:0]    grant,
    output logic [SEL_WIDTH-1:0]  sel,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid
);

    state_t               state, state_n;
    logic [NUM_REQ-1:0]   grant_n;
    logic [SEL_WIDTH-1:0] sel_n;
    logic [1:0]           ptr, ptr_n;
    logic [CNT_WIDTH-1:0] count, count_n;
    logic [1:0]           winner;
    logic                 any;
    logic                 release_now;

    // ptr is one past the last owner, so a releasing owner that still
    // requests is naturally scanned last and only wins when alone.
    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .any    (any)
    );

    Mux4x16 #(.WIDTH(DATA_WIDTH)) u_mux (
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .sel (sel),
        .out (out_data)
    );

    assign release_now = !req[sel]
                       || (count == CNT_WIDTH'(MAX_BURST - 1));

    always_comb begin
        state_n = state;
        grant_n = grant;
        sel_n   = sel;
        ptr_n   = ptr;
        count_n = count;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_n = GRANT;
                    grant_n = onehot4(winner);
                    sel_n   = winner;
                    ptr_n   = winner + 2'd1;
                    count_n = '0;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    count_n = count + CNT_WIDTH'(1);
                end else if (any) begin
                    grant_n = onehot4(winner);
                    sel_n   = winner;
                    ptr_n   = winner + 2'd1;
                    count_n = '0;
                end else begin
                    state_n = IDLE;
                    grant_n = '0;
                    count_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            sel   <= '0;
            ptr   <= 2'd0;
            count <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            sel   <= sel_n;
            ptr   <= ptr_n;
            count <= count_n;
        end
    end

    assign out_valid = (state == GRANT) && req[sel];

endmodule
